// File: rtl/xor_frame_chk.sv
// Registered lane-wise XOR/XNOR reduction on a valid/ready stream, either per beat
// or accumulated into one checksum per s_last-delimited frame.
module xor_frame_chk #(
  parameter int               WIDTH = 8,
  parameter int               LANES = 2,
  parameter int               CNT_W = 16,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LANES*WIDTH-1:0] s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_parity,
  output logic [CNT_W-1:0]       m_beats
);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic             s_fire;
  logic [WIDTH-1:0] beat_x;
  logic [WIDTH-1:0] idle_res;
  logic [WIDTH-1:0] accum_res;
  logic [CNT_W-1:0] cnt_inc;

  // The output register is the only pipeline stage, so a beat can enter
  // whenever that register is empty or is being drained this cycle.
  assign s_ready = !m_valid || m_ready;
  assign s_fire  = s_valid && s_ready;

  // NOTE: every always_comb output gets a default before any conditional or
  // loop update, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    beat_x = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_x = beat_x ^ s_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    idle_res  = (mode[1] ? (SEED ^ beat_x) : beat_x) ^ {WIDTH{mode[0]}};
    accum_res = (acc ^ beat_x) ^ {WIDTH{mode_q == 2'b11}};
    cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mode_q   <= 2'b00;
      acc      <= SEED;
      cnt      <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_parity <= 1'b0;
      m_beats  <= '0;
    end else begin
      // A later load in this block overrides the pop-clear.
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      if (s_fire) begin
        unique case (state)
          IDLE: begin
            mode_q <= mode;
            if (!mode[1] || s_last) begin
              m_valid  <= 1'b1;
              m_data   <= idle_res;
              m_parity <= ^idle_res;
              m_beats  <= CNT_ONE;
            end else begin
              acc   <= SEED ^ beat_x;
              cnt   <= CNT_ONE;
              state <= ACCUM;
            end
          end

          ACCUM: begin
            if (!s_last) begin
              acc <= acc ^ beat_x;
              cnt <= cnt_inc;
            end else begin
              m_valid  <= 1'b1;
              m_data   <= accum_res;
              m_parity <= ^accum_res;
              m_beats  <= cnt_inc;
              acc      <= SEED;
              cnt      <= '0;
              state    <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xor_frame_chk.sv
// Directed bench for xor_frame_chk: the driver queues hand-computed results as beats
// are issued, and an independent monitor checks each result as it is consumed.
module tb_xor_frame_chk;

  localparam int WIDTH = 8;
  localparam int LANES = 2;
  localparam int CNT_W = 2;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             parity;
    logic [CNT_W-1:0] beats;
  } exp_t;

  logic                   clk;
  logic                   rst;
  logic [1:0]             mode;
  logic                   s_valid;
  logic                   s_ready;
  logic [LANES*WIDTH-1:0] s_data;
  logic                   s_last;
  logic                   m_valid;
  logic                   m_ready;
  logic [WIDTH-1:0]       m_data;
  logic                   m_parity;
  logic [CNT_W-1:0]       m_beats;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  xor_frame_chk #(
    .WIDTH(WIDTH),
    .LANES(LANES),
    .CNT_W(CNT_W),
    .SEED (8'h00)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_parity(m_parity),
    .m_beats (m_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one beat, queue its result if it produces one, and hold until accepted.
  task automatic send(input logic [1:0] md, input logic [7:0] l1, input logic [7:0] l0,
                      input logic last, input logic has_out,
                      input logic [7:0] ed, input logic [1:0] eb);
    logic rdy;
    logic accepted;
    exp_t e;
    accepted = 1'b0;
    mode     = md;
    s_data   = {l1, l0};
    s_last   = last;
    s_valid  = 1'b1;
    if (has_out) begin
      e.data   = ed;
      e.parity = ^ed;
      e.beats  = eb;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      accepted = rdy;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("beat_accepted", {31'b0, accepted}, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every result consumed at the coming edge must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && m_valid && m_ready) begin
        check("out_expected", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("m_data",   {24'b0, m_data},   {24'b0, e.data});
          check("m_parity", {31'b0, m_parity}, {31'b0, e.parity});
          check("m_beats",  {30'b0, m_beats},  {30'b0, e.beats});
        end
      end
    end
  end

  initial begin
    rst     = 1'b0;
    mode    = 2'b00;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    #12;
    check("rst_m_valid",  {31'b0, m_valid},  32'd0);
    check("rst_m_data",   {24'b0, m_data},   32'd0);
    check("rst_m_parity", {31'b0, m_parity}, 32'd0);
    check("rst_m_beats",  {30'b0, m_beats},  32'd0);
    check("rst_s_ready",  {31'b0, s_ready},  32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    // Per-beat XOR, then back-to-back beats
    send(2'b00, 8'hA5, 8'h3C, 1'b0, 1'b1, 8'h99, 2'd1);
    check("latency_valid", {31'b0, m_valid}, 32'd1);
    send(2'b00, 8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF, 2'd1);
    send(2'b00, 8'h01, 8'h00, 1'b1, 1'b1, 8'h01, 2'd1);
    idle(2);

    // Per-beat XNOR
    send(2'b01, 8'hA5, 8'h3C, 1'b0, 1'b1, 8'h66, 2'd1);
    idle(2);

    // Three-beat frame XOR, then a single-beat frame
    send(2'b10, 8'h02, 8'h01, 1'b0, 1'b0, 8'h00, 2'd0);
    check("no_out_beat1", {31'b0, m_valid}, 32'd0);
    send(2'b10, 8'h08, 8'h04, 1'b0, 1'b0, 8'h00, 2'd0);
    check("no_out_beat2", {31'b0, m_valid}, 32'd0);
    send(2'b10, 8'h20, 8'h10, 1'b1, 1'b1, 8'h3F, 2'd3);
    send(2'b10, 8'h0F, 8'hFF, 1'b1, 1'b1, 8'hF0, 2'd1);
    idle(2);

    // Backpressure: first result held while the next beat waits
    m_ready = 1'b0;
    send(2'b00, 8'h22, 8'h11, 1'b0, 1'b1, 8'h33, 2'd1);
    fork
      send(2'b00, 8'h44, 8'h00, 1'b0, 1'b1, 8'h44, 2'd1);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_s_ready", {31'b0, s_ready}, 32'd0);
          check("bp_m_valid", {31'b0, m_valid}, 32'd1);
          check("bp_m_data",  {24'b0, m_data},  32'h33);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    idle(2);

    // Mode input ignored after the first beat of a frame
    send(2'b11, 8'h02, 8'h01, 1'b0, 1'b0, 8'h00, 2'd0);
    send(2'b00, 8'h08, 8'h04, 1'b1, 1'b1, 8'hF0, 2'd2);
    idle(2);

    // Beat counter saturates at its maximum (3 for a 2-bit counter)
    send(2'b10, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0);
    send(2'b10, 8'h02, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0);
    send(2'b10, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0);
    send(2'b10, 8'h08, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0);
    send(2'b10, 8'h10, 8'h00, 1'b1, 1'b1, 8'h1F, 2'd3);
    idle(2);

    // Reset mid-frame discards the partial frame
    send(2'b10, 8'h12, 8'h34, 1'b0, 1'b0, 8'h00, 2'd0);
    send(2'b10, 8'h56, 8'h78, 1'b0, 1'b0, 8'h00, 2'd0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_m_valid",  {31'b0, m_valid},  32'd0);
    check("mid_rst_m_data",   {24'b0, m_data},   32'd0);
    check("mid_rst_m_parity", {31'b0, m_parity}, 32'd0);
    check("mid_rst_m_beats",  {30'b0, m_beats},  32'd0);
    check("mid_rst_s_ready",  {31'b0, s_ready},  32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    send(2'b10, 8'h00, 8'hAA, 1'b1, 1'b1, 8'hAA, 2'd1);
    idle(4);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
